// File: rtl/jstk_pkg.sv
// jstk_pkg: shared direction codes and FSM state encoding for the joystick move path
package jstk_pkg;
    localparam int DIR_W = 3;
    typedef enum logic [DIR_W-1:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;
    typedef enum logic [1:0] {ST_IDLE, ST_ARMING, ST_HELD} state_t;
endpackage

// File: rtl/jstk_dir_classify.sv
// jstk_dir_classify: registers a joystick sample and classifies it into a direction
//   clk, rst (sync, active-low)
//   smp_valid/smp_x/smp_y : raw sample strobe and axes
//   cls_valid/cls_dir     : one-cycle pulse with the direction of the registered sample
//   cur_dir               : registered copy of the last classified direction
module jstk_dir_classify
    import jstk_pkg::*;
#(
    parameter int DATA_W   = 10,
    parameter int CENTER   = 512,
    parameter int DEADZONE = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_x,
    input  logic [DATA_W-1:0] smp_y,
    output dir_t              cls_dir,
    output logic              cls_valid,
    output dir_t              cur_dir
);
    localparam int W = DATA_W + 1;
    logic [DATA_W-1:0] x_q, y_q;
    logic              v_q;
    dir_t              cur_q, dir_d;
    logic signed [W-1:0] dx, dy;
    logic [W-1:0]        ax, ay;
    assign dx = {1'b0, x_q} - W'(CENTER);
    assign dy = {1'b0, y_q} - W'(CENTER);
    // -(-2^(W-1)) wraps to the same bit pattern, which read unsigned is the right magnitude
    assign ax = dx[W-1] ? -dx : dx;
    assign ay = dy[W-1] ? -dy : dy;
    // ties fall through to the vertical axis
    assign dir_d = (ax <= W'(DEADZONE) && ay <= W'(DEADZONE)) ? DIR_NONE :
                   (ax > ay) ? ((!dx[W-1] && |dx) ? DIR_RIGHT : DIR_LEFT) :
                   ((!dy[W-1] && |dy) ? DIR_UP : DIR_DOWN);
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q   <= '0;
            y_q   <= '0;
            v_q   <= 1'b0;
            cur_q <= DIR_NONE;
        end else begin
            v_q <= smp_valid;
            if (smp_valid) begin
                x_q <= smp_x;
                y_q <= smp_y;
            end
            if (v_q) cur_q <= dir_d;
        end
    end
    assign cls_dir   = dir_d;
    assign cls_valid = v_q;
    assign cur_dir   = cur_q;
endmodule

// File: rtl/jstk_move_event.sv
// jstk_move_event: turns joystick samples into one-shot move commands with hold qualification
//   clk, rst (sync, active-low)
//   smp_valid/smp_x/smp_y : raw sample strobe and axes
//   move_valid/move_ready/move_dir : single-entry move output handshake
//   cur_dir : live classified direction; drop : sticky, a move was lost to a full buffer
module jstk_move_event
    import jstk_pkg::*;
#(
    parameter int DATA_W         = 10,
    parameter int CENTER         = 512,
    parameter int DEADZONE       = 128,
    parameter int HOLD_SAMPLES   = 4,
    parameter int REPEAT_EN      = 0,
    parameter int REPEAT_SAMPLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_x,
    input  logic [DATA_W-1:0] smp_y,
    output logic              move_valid,
    input  logic              move_ready,
    output logic [DIR_W-1:0]  move_dir,
    output logic [DIR_W-1:0]  cur_dir,
    output logic              drop
);
    localparam int CMAX = HOLD_SAMPLES > REPEAT_SAMPLES ? HOLD_SAMPLES : REPEAT_SAMPLES;
    localparam int CW   = $clog2(CMAX + 1);
    dir_t          cls_dir, cur;
    logic          cls_valid;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    dir_t          dir_q, dir_d, md_q, md_d;
    logic          mv_q, mv_d, drop_q, drop_d;
    logic          emit, accept, load;
    jstk_dir_classify #(
        .DATA_W  (DATA_W),
        .CENTER  (CENTER),
        .DEADZONE(DEADZONE)
    ) u_cls (
        .clk      (clk),
        .rst      (rst),
        .smp_valid(smp_valid),
        .smp_x    (smp_x),
        .smp_y    (smp_y),
        .cls_dir  (cls_dir),
        .cls_valid(cls_valid),
        .cur_dir  (cur)
    );
    assign cnt_inc = cnt_q + CW'(1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        emit    = 1'b0;
        if (cls_valid) begin
            case (state_q)
                ST_IDLE:
                    if (cls_dir != DIR_NONE) begin
                        dir_d   = cls_dir;
                        state_d = (HOLD_SAMPLES == 1) ? ST_HELD : ST_ARMING;
                        cnt_d   = (HOLD_SAMPLES == 1) ? CW'(0) : CW'(1);
                        emit    = (HOLD_SAMPLES == 1);
                    end
                ST_ARMING:
                    if (cls_dir == DIR_NONE) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cls_dir != dir_q) begin
                        dir_d = cls_dir;
                        cnt_d = CW'(1);
                    end else if (cnt_inc == CW'(HOLD_SAMPLES)) begin
                        emit    = 1'b1;
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                ST_HELD:
                    // a different direction is ignored: the stick must recentre first
                    if (cls_dir == DIR_NONE) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cls_dir == dir_q && REPEAT_EN != 0) begin
                        emit  = (cnt_inc == CW'(REPEAT_SAMPLES));
                        cnt_d = emit ? CW'(0) : cnt_inc;
                    end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        accept = mv_q & move_ready;
        load   = emit & (~mv_q | accept);
        mv_d   = load | (mv_q & ~accept);
        md_d   = load ? dir_d : md_q;
        drop_d = drop_q | (emit & ~load);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_NONE;
            mv_q    <= 1'b0;
            md_q    <= DIR_NONE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mv_q    <= mv_d;
            md_q    <= md_d;
            drop_q  <= drop_d;
        end
    end
    assign move_valid = mv_q;
    assign move_dir   = md_q;
    assign cur_dir    = cur;
    assign drop       = drop_q;
endmodule

// File: doc/jstk_move_event.md
# jstk_move_event

Converts raw PmodJSTK joystick samples into discrete, one-shot 2048 move commands (up/down/left/right) for the game core. It sits between the joystick SPI reader and the game-state logic. It applies a centred deadzone and a dominant-axis decision, then requires a hold-time qualification before emitting a move. Moves are issued through a valid/ready handshake, with optional auto-repeat while the stick is held.

## Interface
- DATA_W, 10, width of each axis sample (unsigned)
- CENTER, 512, axis value at rest
- DEADZONE, 128, max |sample − CENTER| treated as centred
- HOLD_SAMPLES, 4, consecutive same-direction samples required before a move (≥1)
- REPEAT_EN, 0, 1 = re-emit a move while the direction stays held
- REPEAT_SAMPLES, 32, same-direction samples between repeats (≥1)

- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- smp_valid  in  1  one-cycle strobe: new sample on smp_x/smp_y
- smp_x  in  DATA_W  X axis; larger = right
- smp_y  in  DATA_W  Y axis; larger = up
- move_valid  out  1  move available
- move_ready  in  1  consumer accepts move
- move_dir  out  3  move code, stable while move_valid
- cur_dir  out  3  current classified direction (live, for LEDs)
- drop  out  1  sticky: a move was discarded because the buffer was full

## Operation
- Direction codes: NONE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4. Codes 5–7 are never produced.
- Classification uses signed DATA_W+1 offsets dx = x − CENTER and dy = y − CENTER, with magnitudes |dx| and |dy|.
  - If both magnitudes ≤ DEADZONE: NONE.
  - Else if |dx| > |dy|: RIGHT when dx > 0, else LEFT.
  - Else: UP when dy > 0, else DOWN. An exact tie goes vertical.
- FSM states: IDLE, ARMING, HELD. A hold counter counts same-direction samples. The FSM advances only on classified samples.
  - IDLE: a non-NONE direction d goes to ARMING with cnt=1 and dir=d. If HOLD_SAMPLES=1, it goes directly to HELD and emits.
  - ARMING:
    - Same d: cnt+1. When cnt reaches HOLD_SAMPLES, emit d, go to HELD, and set cnt=0.
    - A different non-NONE direction restarts ARMING with cnt=1 and the new direction.
    - NONE returns to IDLE.
  - HELD:
    - NONE returns to IDLE.
    - A different non-NONE direction is ignored; the stick must return to centre between distinct moves.
    - Same d with REPEAT_EN=1: cnt+1. On reaching REPEAT_SAMPLES, emit d and set cnt=0.
- Output buffer holds a single entry:
  - An emit loads move_dir and sets move_valid.
  - The entry clears when move_valid && move_ready.
  - If an emit occurs while the buffer is occupied and not being accepted that cycle, the new move is discarded, drop is set, and the held move_dir is unchanged.
  - If an emit coincides with an accept, the new move is loaded and there is no drop.
- drop clears only on reset.

## Timing
- Reset (rst=0 at a clk edge): state=IDLE, cnt=0, cur_dir=NONE, move_valid=0, move_dir=NONE, drop=0. Reset takes effect at the next edge, including in the middle of a handshake.
- Stage 1: the sample is registered on the edge ending its smp_valid cycle.
- Stage 2: classification and FSM update happen on the following edge. cur_dir updates on this same edge.
- Latency: move_valid rises 2 edges after the smp_valid cycle of the qualifying sample.
- Throughput: back-to-back smp_valid is supported, one sample per cycle.
- move_dir and move_valid are registered and hold steady until accepted.

## Structure
- Package jstk_pkg holds:
  - dir_t, a 3-bit enum with the codes above
  - DIR_W = 3
- Sub-module jstk_dir_classify, parametrised by DATA_W, CENTER and DEADZONE:
  - contains the sample register and the deadzone/dominant-axis logic
  - outputs a registered dir_t and a one-cycle cls_valid
- The FSM, counter and output buffer live in jstk_move_event.

## Test plan
- Defaults, with move_ready=1:
  - 4 samples (512,900) → exactly one move_dir=UP, 2 cycles after the 4th strobe.
  - 3 samples followed by (512,512) → no move.
- Deadzone and tie cases:
  - (640,512) → cur_dir=NONE, because the offset equals DEADZONE.
  - (641,512) → RIGHT.
  - (900,124) → DOWN; |dx| = |dy| = 388 is a tie and goes vertical.
- Held stick, REPEAT_EN=0: 100 samples (100,512) → one LEFT only.
- Then (900,512) without returning to centre → no RIGHT.
- Then centre followed by 4×(900,512) → one RIGHT.
- REPEAT_EN=1, REPEAT_SAMPLES=8: 4+16 samples UP → 3 UP moves.
- Backpressure, move_ready=0:
  - Emit UP, then centre, then 4×DOWN → move_dir stays UP and drop=1.
  - With move_ready pulsed on the DOWN emit cycle instead → DOWN is loaded and drop=0.
- rst=0 while move_valid=1 and state=HELD → the next edge gives all outputs at reset values.
- After release: 4 same-direction samples are needed again to produce a move.
